// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: per-cycle L0/L1 event strobes and the
// performance-counter index map used by hardware, software headers and benches.
package snitch_icache_pkg;

  localparam int unsigned NUM_PERF_CNT = 13;
  localparam int unsigned L0_PERF_BASE = 0;
  localparam int unsigned L1_PERF_BASE = 7;
  localparam int unsigned NUM_L0_PERF  = 7;
  localparam int unsigned NUM_L1_PERF  = 6;

  // Field order (MSB first) defines the counter index order.
  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
    logic l0_tag_parity_error;
    logic l0_data_parity_error;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
    logic l1_tag_parity_error;
    logic l1_data_parity_error;
  } icache_l1_events_t;

  typedef enum logic [3:0] {
    PERF_L0_MISS              = 4'd0,
    PERF_L0_HIT               = 4'd1,
    PERF_L0_PREFETCH          = 4'd2,
    PERF_L0_DOUBLE_HIT        = 4'd3,
    PERF_L0_STALL             = 4'd4,
    PERF_L0_TAG_PARITY_ERROR  = 4'd5,
    PERF_L0_DATA_PARITY_ERROR = 4'd6,
    PERF_L1_MISS              = 4'd7,
    PERF_L1_HIT               = 4'd8,
    PERF_L1_STALL             = 4'd9,
    PERF_L1_HANDLER_STALL     = 4'd10,
    PERF_L1_TAG_PARITY_ERROR  = 4'd11,
    PERF_L1_DATA_PARITY_ERROR = 4'd12
  } icache_perf_idx_e;

  // Width needed to hold a popcount over nr_ports strobes.
  function automatic int unsigned perf_inc_width(int unsigned nr_ports);
    return (nr_ports < 1) ? 1 : $clog2(nr_ports + 1);
  endfunction

endpackage

// File: rtl/snitch_icache_perf_sat_cnt.sv
// Single saturating event counter: clear beats increment, and once the counter
// reaches all-ones it stays there until cleared or reset.
module snitch_icache_perf_sat_cnt #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned INC_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, q} + (CNT_W+1)'(inc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/snitch_icache_perf_counters.sv
// Instruction-cache performance counter bank with a single-outstanding read port.
// Optional shadow snapshot bank enabled by SNITCH_ICACHE_PERF_SNAPSHOT_EN.
module snitch_icache_perf_counters
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
  input  logic                                   snapshot_i,
  input  logic                                   rd_snap_i,
`endif
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  icache_l1_events_t                      l1_events_i,
  input  logic                                   rd_req_i,
  input  logic [3:0]                             rd_addr_i,
  output logic                                   rd_valid_o,
  output logic [CNT_W-1:0]                       rd_data_o,
  output logic                                   rd_err_o
);

  localparam int unsigned NUM_CNT = NUM_PERF_CNT;
  localparam int unsigned INC_W   = perf_inc_width(NR_FETCH_PORTS);

  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_q;
  icache_l1_events_t                      l1_q;
  logic                                   en_q;

  logic [NR_FETCH_PORTS*NUM_L0_PERF-1:0]  l0_flat;
  logic [NUM_L1_PERF-1:0]                 l1_flat;
  logic [INC_W-1:0]                       inc [NUM_CNT];
  logic [CNT_W-1:0]                       cnt [NUM_CNT];

  logic [CNT_W-1:0]                       sel_data;
  logic                                   addr_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l0_q <= '0;
      l1_q <= '0;
      en_q <= 1'b0;
    end else begin
      l0_q <= l0_events_i;
      l1_q <= l1_events_i;
      en_q <= enable_i;
    end
  end

  assign l0_flat = l0_q;
  assign l1_flat = l1_q;

  // Field k sits at bit (width-1-k) of each struct, so index order matches field order.
  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      inc[k] = '0;
    end
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      for (int k = 0; k < NUM_L0_PERF; k++) begin
        inc[L0_PERF_BASE+k] = inc[L0_PERF_BASE+k]
                            + INC_W'(l0_flat[p*NUM_L0_PERF + NUM_L0_PERF-1-k]);
      end
    end
    for (int k = 0; k < NUM_L1_PERF; k++) begin
      inc[L1_PERF_BASE+k] = INC_W'(l1_flat[NUM_L1_PERF-1-k]);
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : gen_cnt
    snitch_icache_perf_sat_cnt #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (en_q),
      .clr   (clear_i),
      .inc   (inc[i]),
      .q     (cnt[i])
    );
  end

`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NUM_CNT];

  // Shadow captures the pre-update live values, so a same-cycle clear is not seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= '0;
      end
    end else if (snapshot_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= cnt[i];
      end
    end
  end
`endif

  always_comb begin
    sel_data = '0;
    addr_ok  = (rd_addr_i < 4'(NUM_CNT));
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr_i == 4'(i)) begin
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
        sel_data = rd_snap_i ? shadow[i] : cnt[i];
`else
        sel_data = cnt[i];
`endif
      end
    end
  end

  // Response holds its last data/err while no request is outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_data_o <= addr_ok ? sel_data : '0;
        rd_err_o  <= ~addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Self-checking bench: directed table/sequences plus randomized traffic against
// a cycle-level arithmetic model of the counter bank.
module tb_snitch_icache_perf_counters;
  import snitch_icache_pkg::*;

  localparam int     P    = 4;
  localparam int     W    = 8;
  localparam int     N    = NUM_PERF_CNT;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, enable, clear, req;
  logic [3:0]                    addr;
  icache_l0_events_t [P-1:0]     l0_ev;
  icache_l1_events_t             l1_ev;
  logic                          rd_valid;
  logic [W-1:0]                  rd_data;
  logic                          rd_err;
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
  logic                          snapshot, rd_snap;
`endif

  snitch_icache_perf_counters #(.NR_FETCH_PORTS(P), .CNT_W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .clear_i     (clear),
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
    .snapshot_i  (snapshot),
    .rd_snap_i   (rd_snap),
`endif
    .l0_events_i (l0_ev),
    .l1_events_i (l1_ev),
    .rd_req_i    (req),
    .rd_addr_i   (addr),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .rd_err_o    (rd_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint mcnt    [N];
  longint mshadow [N];
  int     pend    [N];
  bit     pend_en;
  bit     exp_valid;
  longint exp_data;
  bit     exp_err;

  typedef struct {
    logic [3:0] addr;
    longint     data;
    bit         err;
  } vec_t;
  vec_t vecs [16];

  function automatic bit l0_field(icache_l0_events_t e, int k);
    case (k)
      0: return e.l0_miss;
      1: return e.l0_hit;
      2: return e.l0_prefetch;
      3: return e.l0_double_hit;
      4: return e.l0_stall;
      5: return e.l0_tag_parity_error;
      6: return e.l0_data_parity_error;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit l1_field(icache_l1_events_t e, int k);
    case (k)
      0: return e.l1_miss;
      1: return e.l1_hit;
      2: return e.l1_stall;
      3: return e.l1_handler_stall;
      4: return e.l1_tag_parity_error;
      5: return e.l1_data_parity_error;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs applied in this cycle.
  task automatic model_step();
    bit use_snap;
    use_snap = 1'b0;
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
    use_snap = rd_snap;
`endif
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mcnt[i] = 0; mshadow[i] = 0; pend[i] = 0;
      end
      pend_en = 1'b0; exp_valid = 1'b0; exp_data = 0; exp_err = 1'b0;
      return;
    end
    exp_valid = req;
    if (req) begin
      if (int'(addr) >= N) begin
        exp_data = 0; exp_err = 1'b1;
      end else begin
        exp_data = use_snap ? mshadow[addr] : mcnt[addr];
        exp_err  = 1'b0;
      end
    end
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
    if (snapshot) for (int i = 0; i < N; i++) mshadow[i] = mcnt[i];
`endif
    for (int i = 0; i < N; i++) begin
      if (clear) mcnt[i] = 0;
      else if (pend_en) mcnt[i] = (mcnt[i] + pend[i] > MAXV) ? MAXV : mcnt[i] + pend[i];
    end
    for (int k = 0; k < 7; k++) begin
      pend[k] = 0;
      for (int p = 0; p < P; p++) pend[k] += int'(l0_field(l0_ev[p], k));
    end
    for (int k = 0; k < 6; k++) pend[7+k] = int'(l1_field(l1_ev, k));
    pend_en = enable;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rd_valid", 64'(rd_valid), 64'(exp_valid));
    check("rd_data", 64'(rd_data), exp_data);
    check("rd_err", 64'(rd_err), 64'(exp_err));
  endtask

  task automatic read_expect(logic [3:0] a, longint d, bit e, string name);
    req = 1'b1; addr = a;
    tick();
    req = 1'b0;
    check(name, 64'(rd_data), d);
    check({name, "_err"}, 64'(rd_err), 64'(e));
  endtask

  task automatic idle_inputs();
    enable = 1'b1; clear = 1'b0; req = 1'b0; addr = 4'd0;
    l0_ev = '0; l1_ev = '0;
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
    snapshot = 1'b0; rd_snap = 1'b0;
`endif
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Table: reset values and out-of-range indices
    for (int i = 0; i < 13; i++) vecs[i] = '{addr: 4'(i), data: 0, err: 1'b0};
    vecs[13] = '{addr: 4'd13, data: 0, err: 1'b1};
    vecs[14] = '{addr: 4'd15, data: 0, err: 1'b1};
    vecs[15] = '{addr: 4'd12, data: 0, err: 1'b0};
    for (int i = 0; i < 16; i++) begin
      req = 1'b1; addr = vecs[i].addr;
      tick();
      check("tbl_valid", 64'(rd_valid), 64'd1);
      check("tbl_data", 64'(rd_data), vecs[i].data);
      check("tbl_err", 64'(rd_err), 64'(vecs[i].err));
    end
    req = 1'b0;
    tick();
    check("no_req_valid", 64'(rd_valid), 64'd0);

    // Three ports hit for five cycles; early read sees only the first cycle
    do_clear(); tick(); tick();
    for (int p = 0; p < 3; p++) l0_ev[p].l0_hit = 1'b1;
    tick(); tick();
    req = 1'b1; addr = 4'(PERF_L0_HIT);
    tick();
    req = 1'b0;
    check("hit_early", 64'(rd_data), 64'd3);
    tick(); tick();
    l0_ev = '0;
    tick(); tick();
    read_expect(4'(PERF_L0_HIT), 15, 1'b0, "hit_total");

    // Saturation at 2^W-1 and recovery via clear
    do_clear();
    l1_ev.l1_miss = 1'b1;
    repeat (300) tick();
    l1_ev.l1_miss = 1'b0;
    tick(); tick();
    read_expect(4'(PERF_L1_MISS), 255, 1'b0, "sat");
    l1_ev.l1_miss = 1'b1;
    repeat (10) tick();
    l1_ev.l1_miss = 1'b0;
    tick(); tick();
    read_expect(4'(PERF_L1_MISS), 255, 1'b0, "sat_hold");
    do_clear();
    read_expect(4'(PERF_L1_MISS), 0, 1'b0, "sat_clear");

    // Clear drops the increment it collides with, but not the event presented with it
    tick(); tick();
    l1_ev.l1_hit = 1'b1;
    tick();
    l1_ev.l1_hit = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    read_expect(4'(PERF_L1_HIT), 0, 1'b0, "clr_drop");
    l1_ev.l1_hit = 1'b1; clear = 1'b1;
    tick();
    l1_ev.l1_hit = 1'b0; clear = 1'b0;
    tick();
    read_expect(4'(PERF_L1_HIT), 1, 1'b0, "clr_same_cycle");

    // Disabled counting holds the counter
    enable = 1'b0; l1_ev.l1_hit = 1'b1;
    tick(); tick(); tick();
    l1_ev.l1_hit = 1'b0; enable = 1'b1;
    tick(); tick();
    read_expect(4'(PERF_L1_HIT), 1, 1'b0, "enable_hold");

`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
    do_clear(); tick();
    l0_ev[0].l0_stall = 1'b1;
    repeat (10) tick();
    l0_ev = '0;
    tick(); tick();
    snapshot = 1'b1; clear = 1'b1;
    tick();
    snapshot = 1'b0; clear = 1'b0;
    l0_ev[1].l0_stall = 1'b1;
    repeat (4) tick();
    l0_ev = '0;
    tick(); tick();
    rd_snap = 1'b1;
    read_expect(4'(PERF_L0_STALL), 10, 1'b0, "snap_shadow");
    rd_snap = 1'b0;
    read_expect(4'(PERF_L0_STALL), 4, 1'b0, "snap_live");
`endif

    // Reset in the same cycle as a request suppresses the response
    req = 1'b1; addr = 4'd13; rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("rst_no_valid", 64'(rd_valid), 64'd0);
    check("rst_err", 64'(rd_err), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < P; p++) l0_ev[p] = icache_l0_events_t'(7'($urandom & $urandom));
      l1_ev  = icache_l1_events_t'(6'($urandom & $urandom));
      enable = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 63) == 0);
      rst    = ($urandom_range(0, 499) == 0);
      req    = 1'($urandom_range(0, 1));
      addr   = 4'($urandom_range(0, 15));
`ifdef SNITCH_ICACHE_PERF_SNAPSHOT_EN
      snapshot = ($urandom_range(0, 31) == 0);
      rd_snap  = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
Name: snitch_icache_perf_counters

Overview:
- Consumes the per-cycle L0 and L1 instruction-cache event strobes (icache_l0_events_t, icache_l1_events_t) from the cache stages.
- Accumulates them into a bank of saturating counters.
- Exposes a single-outstanding read port for the cluster peripheral/CSR layer.
- Sits directly downstream of the cache event outputs; has no influence on cache timing.

Parameters:
- NR_FETCH_PORTS, 1, number of L0 event inputs; all are summed into one counter per event type.
- CNT_W, 32, width of each counter, legal range 8..64.
- NUM_CNT, 13, number of counters: 7 L0 plus 6 L1. Derived; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  counting enable; when low, counters hold.
- clear_i  in  1  one-cycle strobe that zeroes all counters.
- l0_events_i  in  NR_FETCH_PORTS x icache_l0_events_t  per-port L0 event strobes.
- l1_events_i  in  icache_l1_events_t  L1 event strobes.
- rd_req_i  in  1  read request; always accepted.
- rd_addr_i  in  4  counter index.
- rd_valid_o  out  1  read response valid.
- rd_data_o  out  CNT_W  read data.
- rd_err_o  out  1  index out of range.

Behaviour:
- Counter index map, in struct field order MSB first:
  - 0 l0_miss, 1 l0_hit, 2 l0_prefetch, 3 l0_double_hit, 4 l0_stall, 5 l0_tag_parity_error, 6 l0_data_parity_error.
  - 7 l1_miss, 8 l1_hit, 9 l1_stall, 10 l1_handler_stall, 11 l1_tag_parity_error, 12 l1_data_parity_error.
- Input stage:
  - All event inputs and enable_i are registered once (event pipeline register). Counters change one cycle after that register, so the count is visible to a read issued 2 cycles after the event cycle.
  - The pipeline register resets to 0.
- Increment:
  - L0 counter k adds the popcount of field k across all ports. Increment width is $clog2(NR_FETCH_PORTS+1), zero-extended to CNT_W+1 before the add.
  - L1 counters add 0 or 1.
- Saturation: if the (CNT_W+1)-bit sum exceeds 2^CNT_W-1, the counter loads all-ones and stays there until clear or reset. There is no wrap-around.
- Enable: the increment applies only if the registered enable is 1. Toggling enable_i takes effect with the same 1-cycle skew as the events.
- Clear:
  - clear_i is unregistered. When it is high, every counter is 0 in the next cycle.
  - Clear has priority over any increment in the same cycle; that increment is dropped.
  - Events still held in the pipeline register are counted in the cycle after the clear.
- Read:
  - A request in cycle N gives rd_valid_o=1 in N+1. rd_data_o is the counter value as it was in cycle N, before that cycle's update or clear.
  - Back-to-back requests are allowed, one per cycle.
  - rd_valid_o is 0 in any cycle following no request.
  - rd_data_o and rd_err_o are held at their last value when invalid.
  - For rd_addr_i >= NUM_CNT: rd_data_o=0 and rd_err_o=1. For a valid index, rd_err_o=0.
- Reset:
  - All counters, the pipeline register, rd_valid_o, rd_data_o and rd_err_o become 0.
  - Reset mid-operation discards any pending response; no rd_valid_o appears in the cycle after reset.
- No state machine is needed beyond the response-valid flop. The block is pure datapath plus a single pipeline stage.

Optional Feature:
- Macro: SNITCH_ICACHE_PERF_SNAPSHOT_EN.
- With the macro defined:
  - Adds ports snapshot_i (in, 1) and rd_snap_i (in, 1), plus a NUM_CNT x CNT_W shadow bank.
  - snapshot_i copies all live counters into the shadow bank at the clock edge. The copied value is the pre-update value of that cycle.
  - If snapshot_i and clear_i are high in the same cycle, the shadow gets the old values and the live counters clear.
  - A read with rd_snap_i=1 returns the shadow value. The shadow bank resets to 0.
- Without the macro: no extra ports or storage; all reads return live values.

Decomposition:
- snitch_icache_pkg gets:
  - localparam NUM_PERF_CNT=13.
  - localparams L0_PERF_BASE=0 and L1_PERF_BASE=7.
  - A typedef enum icache_perf_idx_e with the index map above, so software headers and the bench share it.
- One natural sub-module: snitch_icache_perf_sat_cnt. It is a single CNT_W counter with inputs inc (variable width), en and clr, and implements the saturation and clear-priority logic. It is instantiated NUM_CNT times.

Test Plan:
- Reset, then read idx 0..12 -> rd_valid_o one cycle after each request, all data 0, rd_err_o=0.
- NR_FETCH_PORTS=4; hold l0_hit high on 3 ports for 5 cycles with enable_i=1 -> counter 1 reads 15. Reading exactly 2 cycles after the first event cycle -> 3.
- CNT_W=8; pulse l1_miss 300 cycles -> counter 7 reads 255 and stays 255 after 10 more events. Then clear_i -> reads 0.
- clear_i in the same cycle as an l1_hit pulse registered in the previous cycle -> counter 8 is 0 after clear. An l1_hit presented in the clear cycle itself is counted -> reads 1.
- Read addr 13 and 15 -> rd_err_o=1, rd_data_o=0. Read addr 12 immediately after -> rd_err_o=0.
- With SNITCH_ICACHE_PERF_SNAPSHOT_EN: count 10 l0_stall, snapshot_i together with clear_i, count 4 more -> rd_snap_i=1 read gives 10, live read gives 4.
